// File: rtl/matrix_framebuf.sv
// matrix_framebuf: double-buffered gs x gs frame store that swaps banks only between scanner frames.
module matrix_framebuf #(
  parameter int gs      = 8,
  parameter int GAP_CYC = 2,
  localparam int RW     = $clog2(gs)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [RW-1:0]      wr_row_i,
  input  logic [gs-1:0]      wr_data_i,
  input  logic               swap_req_i,
  output logic               swap_pending_o,
  input  logic               enable_i,
  output logic [gs*gs-1:0]   matrix_o,
  output logic               e_disp_o,
  input  logic               d_disp_i,
  output logic [7:0]         frame_cnt_o,
  output logic               err_o
);
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;
  state_t state, state_d;
  logic [gs*gs-1:0] bank0, bank1, wmask, wdata;
  logic [RW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic sel, pending, scan_end, gap_end, swap, wr_fire;
  assign scan_end = state == SCAN && cnt == RW'(gs - 1);
  assign gap_end = state == GAP && gcnt == GW'(GAP_CYC - 1);
  assign swap = pending && (scan_end || state == IDLE);
  assign wr_ready_o = !pending;
  assign swap_pending_o = pending;
  assign wr_fire = wr_valid_i && !pending && ({1'b0, wr_row_i} < (RW+1)'(gs));
  assign wmask = (gs*gs)'({gs{1'b1}}) << (gs * wr_row_i);
  assign wdata = (gs*gs)'(wr_data_i) << (gs * wr_row_i);
  assign matrix_o = sel ? bank1 : bank0;
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? (enable_i ? SCAN : IDLE) :
              scan_end ? GAP :
              gap_end ? (enable_i ? SCAN : IDLE) : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      e_disp_o <= 1'b0;
      cnt <= '0;
      gcnt <= '0;
      pending <= 1'b0;
      sel <= 1'b0;
      frame_cnt_o <= '0;
      err_o <= 1'b0;
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      state <= state_d;
      e_disp_o <= state_d == SCAN;
      cnt <= (state == SCAN && !scan_end) ? cnt + 1'b1 : '0;
      gcnt <= (state == GAP && !gap_end) ? gcnt + 1'b1 : '0;
      pending <= swap ? 1'b0 : (pending || swap_req_i);
      if (swap) begin
        sel <= ~sel;
        frame_cnt_o <= frame_cnt_o + 8'd1;
      end
      if (state == GAP && gcnt == '0 && !d_disp_i) err_o <= 1'b1;
      if (wr_fire && sel) bank0 <= (bank0 & ~wmask) | wdata;
      if (wr_fire && !sel) bank1 <= (bank1 & ~wmask) | wdata;
    end
  end
endmodule

// File: tb/tb_matrix_framebuf.sv
// tb_matrix_framebuf: directed checks of writes, swaps, scan timing, error flag and reset.
module tb_matrix_framebuf;
  logic clk_i = 0, rst_ni = 0;
  logic wr_valid_i = 0, wr_ready_o, swap_req_i = 0, swap_pending_o;
  logic enable_i = 0, e_disp_o, d_disp_i = 1, err_o;
  logic [2:0] wr_row_i = 0;
  logic [7:0] wr_data_i = 0, frame_cnt_o;
  logic [63:0] matrix_o;
  int tests = 0, fails = 0;

  matrix_framebuf dut (.clk_i(clk_i), .rst_ni(rst_ni), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_row_i(wr_row_i), .wr_data_i(wr_data_i), .swap_req_i(swap_req_i), .swap_pending_o(swap_pending_o),
    .enable_i(enable_i), .matrix_o(matrix_o), .e_disp_o(e_disp_o), .d_disp_i(d_disp_i),
    .frame_cnt_o(frame_cnt_o), .err_o(err_o));

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    #2;
    chk("rst_matrix", matrix_o, 64'h0);
    chk("rst_edisp", 64'(e_disp_o), 64'h0);
    chk("rst_ready", 64'(wr_ready_o), 64'h1);
    chk("rst_cnt", 64'(frame_cnt_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    rst_ni = 1;
    tick;
    // T1: diagonal pattern
    for (int r = 0; r < 8; r++) begin
      wr_valid_i = 1; wr_row_i = 3'(r); wr_data_i = 8'h01 << r;
      tick;
    end
    wr_valid_i = 0; swap_req_i = 1;
    tick;
    swap_req_i = 0;
    chk("t1_pending", 64'(swap_pending_o), 64'h1);
    chk("t1_ready_low", 64'(wr_ready_o), 64'h0);
    chk("t1_not_yet", matrix_o, 64'h0);
    tick;
    chk("t1_matrix", matrix_o, 64'h8040201008040201);
    chk("t1_cnt", 64'(frame_cnt_o), 64'h1);
    chk("t1_pending_clr", 64'(swap_pending_o), 64'h0);
    enable_i = 1;
    tick;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t1_edisp_%0d", k), 64'(e_disp_o), 64'((k % 10) < 8));
      chk($sformatf("t1_stable_%0d", k), matrix_o, 64'h8040201008040201);
      tick;
    end
    // T2: swap requested in SCAN cycle 2 waits for GAP entry
    wr_valid_i = 1; wr_row_i = 0; wr_data_i = 8'hFF;
    tick;
    wr_valid_i = 0;
    tick;
    swap_req_i = 1;
    tick;
    swap_req_i = 0;
    for (int c = 3; c < 8; c++) begin
      chk($sformatf("t2_pending_c%0d", c), 64'(swap_pending_o), 64'h1);
      chk($sformatf("t2_ready_c%0d", c), 64'(wr_ready_o), 64'h0);
      chk($sformatf("t2_matrix_c%0d", c), matrix_o, 64'h8040201008040201);
      chk($sformatf("t2_edisp_c%0d", c), 64'(e_disp_o), 64'h1);
      tick;
    end
    chk("t2_gap_matrix", matrix_o, 64'h00000000000000FF);
    chk("t2_gap_pending", 64'(swap_pending_o), 64'h0);
    chk("t2_gap_edisp", 64'(e_disp_o), 64'h0);
    chk("t2_cnt", 64'(frame_cnt_o), 64'h2);
    tick;
    chk("t2_err_ok", 64'(err_o), 64'h0);
    // T4: enable drops in SCAN cycle 3; frame completes then IDLE
    tick;
    tick; tick; tick;
    enable_i = 0;
    for (int c = 3; c < 8; c++) begin
      chk($sformatf("t4_edisp_c%0d", c), 64'(e_disp_o), 64'h1);
      tick;
    end
    chk("t4_gap0", 64'(e_disp_o), 64'h0);
    tick;
    chk("t4_gap1", 64'(e_disp_o), 64'h0);
    tick;
    chk("t4_idle0", 64'(e_disp_o), 64'h0);
    tick;
    chk("t4_idle1", 64'(e_disp_o), 64'h0);
    chk("t4_err", 64'(err_o), 64'h0);
    // T5: write and swap request in the same cycle; old front retained as back
    wr_valid_i = 1; wr_row_i = 5; wr_data_i = 8'hAA; swap_req_i = 1;
    tick;
    wr_valid_i = 0; swap_req_i = 0;
    chk("t5_pending", 64'(swap_pending_o), 64'h1);
    tick;
    chk("t5_matrix", matrix_o, 64'h8040AA1008040201);
    chk("t5_row5", 64'(matrix_o[47:40]), 64'hAA);
    chk("t5_cnt", 64'(frame_cnt_o), 64'h3);
    // T6: frame counter wrap
    for (int i = 0; i < 252; i++) begin
      swap_req_i = 1; tick;
      swap_req_i = 0; tick;
    end
    chk("t6_cnt255", 64'(frame_cnt_o), 64'hFF);
    swap_req_i = 1; tick;
    swap_req_i = 0; tick;
    chk("t6_wrap", 64'(frame_cnt_o), 64'h0);
    // T3: scanner never reports frame done
    d_disp_i = 0; enable_i = 1;
    tick;
    for (int c = 0; c < 8; c++) tick;
    chk("t3_err_before", 64'(err_o), 64'h0);
    tick;
    chk("t3_err_set", 64'(err_o), 64'h1);
    d_disp_i = 1;
    for (int i = 0; i < 30; i++) tick;
    chk("t3_err_sticky", 64'(err_o), 64'h1);
    tick; tick; tick;
    chk("t6_mid_scan", 64'(e_disp_o), 64'h1);
    // asynchronous reset mid-SCAN
    #2 rst_ni = 0;
    #1;
    chk("ar_edisp", 64'(e_disp_o), 64'h0);
    chk("ar_matrix", matrix_o, 64'h0);
    chk("ar_err", 64'(err_o), 64'h0);
    chk("ar_cnt", 64'(frame_cnt_o), 64'h0);
    chk("ar_ready", 64'(wr_ready_o), 64'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
